// File: rtl/intra16_mode_sched_if.sv
// Request/response channel between the intra16 mode scheduler and the residual/SAD datapath.
// Latency: n/a (wires only).
// Backpressure: requests stall on req_ready=0; responses are always accepted.
interface intra16_mode_sched_if #(
  parameter int ROWS      = 16,
  parameter int ROW_SAD_W = 12
);
  localparam int ROW_W = $clog2(ROWS);

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_mode;
  logic [ROW_W-1:0]     req_row;
  logic                 rsp_valid;
  logic [ROW_SAD_W-1:0] rsp_sad;

  // Scheduler side: issues row requests, consumes row SADs.
  modport master (
    output req_valid, req_mode, req_row,
    input  req_ready, rsp_valid, rsp_sad
  );

  // Datapath side: accepts row requests, returns row SADs in order.
  modport slave (
    input  req_valid, req_mode, req_row,
    output req_ready, rsp_valid, rsp_sad
  );
endinterface

// File: rtl/intra16_mode_sched.sv
// Sequences candidate intra16x16 modes (V,H,DC,Plane) over the shared SAD datapath and picks the min-SAD mode.
// Latency: per mode ROWS + response latency cycles (latency < MAX_OUT), plus LOAD/DECIDE/DONE cycles.
// Backpressure: requests hold while req_ready=0; at most MAX_OUT outstanding; responses never stalled.
module intra16_mode_sched #(
  parameter int ROWS      = 16,
  parameter int ROW_SAD_W = 12,
  parameter int ACC_W     = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   avail_top_i,
  input  logic                   avail_left_i,
  output logic                   busy_o,
  intra16_mode_sched_if.master   dp,
  output logic                   done_o,
  output logic [1:0]             best_mode_o,
  output logic [ACC_W-1:0]       best_sad_o,
  output logic [4*ACC_W-1:0]     mode_sads_o,
  output logic [3:0]             mode_tested_o,
  output logic                   err_o
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(ROWS + 1);
  localparam int SUM_W = ((ACC_W > ROW_SAD_W) ? ACC_W : ROW_SAD_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cand_q, cand_d;
  logic [1:0]                  mode_q, mode_d;
  logic [CW-1:0]               issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]               rsp_cnt_q, rsp_cnt_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [3:0][ACC_W-1:0]       mode_sads_q, mode_sads_d;
  logic [3:0]                  mode_tested_q, mode_tested_d;
  logic [1:0]                  best_mode_q, best_mode_d;
  logic [ACC_W-1:0]            best_sad_q, best_sad_d;
  logic                        err_q, err_d;

  logic [CW-1:0]               outstanding;
  logic                        req_vld;
  logic                        rsp_ok;
  logic                        rsp_take;
  logic [SUM_W-1:0]            sum;
  logic [ACC_W-1:0]            acc_new;
  logic [1:0]                  first_mode;
  logic                        has_next;
  logic [1:0]                  next_mode;
  logic                        min_found;
  logic [1:0]                  min_mode;
  logic [ACC_W-1:0]            min_sad;

  // Issue window, saturating accumulate, and candidate / minimum searches.
  always_comb begin
    outstanding = issue_cnt_q - rsp_cnt_q;
    req_vld     = (state_q == S_RUN) && (issue_cnt_q < CW'(ROWS)) && (outstanding < CW'(MAX_OUT));
    rsp_ok      = (state_q == S_RUN) && (outstanding != '0);
    rsp_take    = dp.rsp_valid && rsp_ok;
    sum         = SUM_W'(acc_q) + SUM_W'(dp.rsp_sad);
    if (sum > SUM_W'(ACC_MAX)) acc_new = ACC_MAX;
    else                       acc_new = sum[ACC_W-1:0];

    // Lowest candidate; DC is always a candidate so the default never sticks.
    first_mode = 2'd2;
    for (int m = 3; m >= 0; m--) begin
      if (cand_q[m]) first_mode = 2'(m);
    end

    // Lowest candidate strictly above the mode currently running.
    has_next  = 1'b0;
    next_mode = mode_q;
    for (int m = 3; m >= 0; m--) begin
      if (cand_q[m] && (m > int'(mode_q))) begin
        has_next  = 1'b1;
        next_mode = 2'(m);
      end
    end

    // Minimum over tested modes; strict compare keeps the lowest index on ties.
    min_found = 1'b0;
    min_mode  = 2'd2;
    min_sad   = mode_sads_q[2];
    for (int m = 0; m < 4; m++) begin
      if (mode_tested_q[m] && (!min_found || (mode_sads_q[m] < min_sad))) begin
        min_found = 1'b1;
        min_mode  = 2'(m);
        min_sad   = mode_sads_q[m];
      end
    end
  end

  // Next-state logic for the sequencer and all of its datapath registers.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    mode_d        = mode_q;
    issue_cnt_d   = issue_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    acc_d         = acc_q;
    mode_sads_d   = mode_sads_q;
    mode_tested_d = mode_tested_q;
    best_mode_d   = best_mode_q;
    best_sad_d    = best_sad_q;
    err_d         = err_q | (dp.rsp_valid & ~rsp_ok);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cand_d        = {avail_top_i & avail_left_i, 1'b1, avail_left_i, avail_top_i};
          mode_sads_d   = '0;
          mode_tested_d = '0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        mode_d      = first_mode;
        acc_d       = '0;
        issue_cnt_d = '0;
        rsp_cnt_d   = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (req_vld && dp.req_ready) issue_cnt_d = issue_cnt_q + CW'(1);
        if (rsp_take) begin
          acc_d     = acc_new;
          rsp_cnt_d = rsp_cnt_q + CW'(1);
          // Last row of this mode: commit and roll straight into the next candidate.
          if (rsp_cnt_q == CW'(ROWS - 1)) begin
            mode_sads_d[mode_q]   = acc_new;
            mode_tested_d[mode_q] = 1'b1;
            if (has_next) begin
              mode_d      = next_mode;
              acc_d       = '0;
              issue_cnt_d = '0;
              rsp_cnt_d   = '0;
            end else begin
              state_d = S_DECIDE;
            end
          end
        end
      end
      S_DECIDE: begin
        best_mode_d = min_mode;
        best_sad_d  = min_sad;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      mode_q        <= '0;
      issue_cnt_q   <= '0;
      rsp_cnt_q     <= '0;
      acc_q         <= '0;
      mode_sads_q   <= '0;
      mode_tested_q <= '0;
      best_mode_q   <= 2'd2;
      best_sad_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      mode_q        <= mode_d;
      issue_cnt_q   <= issue_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      acc_q         <= acc_d;
      mode_sads_q   <= mode_sads_d;
      mode_tested_q <= mode_tested_d;
      best_mode_q   <= best_mode_d;
      best_sad_q    <= best_sad_d;
      err_q         <= err_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign dp.req_valid  = req_vld;
  assign dp.req_mode   = mode_q;
  assign dp.req_row    = issue_cnt_q[RW-1:0];
  assign best_mode_o   = best_mode_q;
  assign best_sad_o    = best_sad_q;
  assign mode_sads_o   = mode_sads_q;
  assign mode_tested_o = mode_tested_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_intra16_mode_sched.sv
// Bench for intra16_mode_sched: the bench plays the SAD datapath and scores each run against a model.
// Latency: n/a.
// Backpressure: req_ready driven always-on, patterned or random.
`timescale 1ns/1ps
module tb_intra16_mode_sched;
  localparam int ROWS      = 16;
  localparam int ROW_SAD_W = 12;
  localparam int ACC_W     = 16;
  localparam int MAX_OUT   = 4;
  localparam int ACC_W_S   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 start, start_s;
  logic                 avail_top, avail_left;
  logic                 busy, done, err;
  logic [1:0]           best_mode;
  logic [ACC_W-1:0]     best_sad;
  logic [4*ACC_W-1:0]   mode_sads;
  logic [3:0]           mode_tested;
  logic                 busy_s, done_s, err_s;
  logic [1:0]           best_mode_s;
  logic [ACC_W_S-1:0]   best_sad_s;
  logic [4*ACC_W_S-1:0] mode_sads_s;
  logic [3:0]           mode_tested_s;

  intra16_mode_sched_if #(.ROWS(ROWS), .ROW_SAD_W(ROW_SAD_W)) dp_if ();
  intra16_mode_sched_if #(.ROWS(ROWS), .ROW_SAD_W(ROW_SAD_W)) dp_s ();

  intra16_mode_sched #(.ROWS(ROWS), .ROW_SAD_W(ROW_SAD_W), .ACC_W(ACC_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .avail_top_i(avail_top), .avail_left_i(avail_left),
    .busy_o(busy), .dp(dp_if), .done_o(done), .best_mode_o(best_mode), .best_sad_o(best_sad),
    .mode_sads_o(mode_sads), .mode_tested_o(mode_tested), .err_o(err)
  );

  intra16_mode_sched #(.ROWS(ROWS), .ROW_SAD_W(ROW_SAD_W), .ACC_W(ACC_W_S), .MAX_OUT(MAX_OUT)) dut_s (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_s), .avail_top_i(avail_top), .avail_left_i(avail_left),
    .busy_o(busy_s), .dp(dp_s), .done_o(done_s), .best_mode_o(best_mode_s), .best_sad_o(best_sad_s),
    .mode_sads_o(mode_sads_s), .mode_tested_o(mode_tested_s), .err_o(err_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sad_tab [4][ROWS];
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input int v, input int h, input int d, input int p);
    for (int r = 0; r < ROWS; r++) begin
      sad_tab[0][r] = v; sad_tab[1][r] = h; sad_tab[2][r] = d; sad_tab[3][r] = p;
    end
  endtask

  task automatic set_rand();
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < ROWS; r++)
        sad_tab[m][r] = $urandom_range(0, 4095);
  endtask

  // Mode total as the plain sum of its row SADs, clipped to the accumulator range.
  function automatic int exp_total(input int m, input int accw);
    int s = 0;
    for (int r = 0; r < ROWS; r++) s += sad_tab[m][r];
    if (s > (1 << accw) - 1) s = (1 << accw) - 1;
    return s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_valid"}, dp_if.req_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_best_mode"}, best_mode, 2);
    chk({tag, "_best_sad"}, best_sad, 0);
    chk({tag, "_mode_sads"}, mode_sads, 0);
    chk({tag, "_mode_tested"}, mode_tested, 0);
  endtask

  // One macroblock on the main DUT. rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_mb(input bit top, input bit left, input int lat, input int rdy_mode, input int abort_at);
    int   exp_m[$], exp_r[$];
    int   pend_due[$], pend_sad[$], pend_mode[$];
    int   cyc, n_req, n_rsp, viol_out, viol_stab, viol_order;
    bit   stall, got_done, aborted, rdy;
    logic [1:0] st_mode;
    logic [3:0] st_row;
    bit   cand [4];
    logic [63:0] e_sads;
    int   e_tested, b_mode, b_sad, t;
    bit   found;

    cand[0] = top; cand[1] = left; cand[2] = 1'b1; cand[3] = top & left;
    e_tested = 0;
    for (int m = 0; m < 4; m++) begin
      if (cand[m]) begin
        e_tested |= (1 << m);
        for (int r = 0; r < ROWS; r++) begin exp_m.push_back(m); exp_r.push_back(r); end
      end
    end
    cyc = 0; n_req = 0; n_rsp = 0; viol_out = 0; viol_stab = 0; viol_order = 0;
    stall = 0; got_done = 0; aborted = 0; st_mode = 0; st_row = 0;

    avail_top = top; avail_left = left; start = 1'b1;
    step();
    start = 1'b0;
    avail_top = $urandom_range(0, 1); avail_left = $urandom_range(0, 1);
    chk("busy_after_start", busy, 1);

    while (cyc < 2000) begin
      if (done) begin got_done = 1; break; end
      if (abort_at > 0 && n_rsp >= abort_at) begin aborted = 1; break; end
      if (stall && !(dp_if.req_valid && dp_if.req_mode == st_mode && dp_if.req_row == st_row)) viol_stab++;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dp_if.req_ready = rdy;
      if (dp_if.req_valid && rdy) begin
        if (n_req < exp_m.size()) begin
          chk("req_mode", dp_if.req_mode, exp_m[n_req]);
          chk("req_row", dp_if.req_row, exp_r[n_req]);
        end else viol_order++;
        if (pend_due.size() >= MAX_OUT) viol_out++;
        if (pend_mode.size() > 0 && pend_mode[0] != int'(dp_if.req_mode)) viol_order++;
      end
      dp_if.rsp_valid = 1'b0;
      dp_if.rsp_sad   = ROW_SAD_W'($urandom);
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        dp_if.rsp_valid = 1'b1;
        dp_if.rsp_sad   = ROW_SAD_W'(pend_sad[0]);
        void'(pend_due.pop_front()); void'(pend_sad.pop_front()); void'(pend_mode.pop_front());
        n_rsp++;
      end
      if (dp_if.req_valid && rdy) begin
        pend_due.push_back(cyc + lat);
        pend_sad.push_back(sad_tab[dp_if.req_mode][dp_if.req_row]);
        pend_mode.push_back(int'(dp_if.req_mode));
        n_req++;
      end
      stall   = dp_if.req_valid && !rdy;
      st_mode = dp_if.req_mode;
      st_row  = dp_if.req_row;
      step();
      cyc++;
    end
    dp_if.req_ready = 1'b0;
    dp_if.rsp_valid = 1'b0;

    if (aborted) begin
      rst_n = 1'b0;
      #1;
      exp_err = 1'b0;
      chk_reset("midrun_reset");
      step();
      rst_n = 1'b1;
      step();
      return;
    end

    chk("done_seen", got_done, 1);
    if (got_done) begin
      e_sads = '0; found = 0; b_mode = 0; b_sad = 0;
      for (int m = 0; m < 4; m++) begin
        if (cand[m]) begin
          t = exp_total(m, ACC_W);
          e_sads[m*ACC_W +: ACC_W] = ACC_W'(t);
          if (!found || t < b_sad) begin found = 1; b_mode = m; b_sad = t; end
        end
      end
      chk("busy_at_done", busy, 1);
      chk("req_count", n_req, exp_m.size());
      chk("best_mode", best_mode, b_mode);
      chk("best_sad", best_sad, b_sad);
      chk("mode_sads", mode_sads, e_sads);
      chk("mode_tested", mode_tested, e_tested);
      chk("err", err, exp_err);
      chk("outstanding_limit", viol_out, 0);
      chk("stall_stability", viol_stab, 0);
      chk("mode_order", viol_order, 0);
      step();
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    logic [63:0] saved_sads;
    bit   prev_s;
    int   nreq_s;
    bit   seen_s;

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; avail_top = 1'b0; avail_left = 1'b0;
    dp_if.req_ready = 1'b0; dp_if.rsp_valid = 1'b0; dp_if.rsp_sad = '0;
    dp_s.req_ready  = 1'b0; dp_s.rsp_valid  = 1'b0; dp_s.rsp_sad  = '0;
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    step();

    // Only DC available.
    set_const(10, 10, 10, 10);
    run_mb(1'b0, 1'b0, 2, 0, 0);

    // All modes; H ties DC and wins on lower index.
    set_const(20, 5, 5, 30);
    run_mb(1'b1, 1'b1, 1, 0, 0);

    // Backpressure pattern with long latency.
    set_rand();
    run_mb(1'b1, 1'b1, 6, 1, 0);

    // Random neighbours, latency, ready.
    for (int i = 0; i < 6; i++) begin
      set_rand();
      run_mb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 7), 2, 0);
    end

    // Stray response while idle.
    saved_sads = mode_sads;
    dp_if.rsp_valid = 1'b1;
    dp_if.rsp_sad   = 12'd777;
    step();
    dp_if.rsp_valid = 1'b0;
    exp_err = 1'b1;
    chk("stray_err", err, 1);
    chk("stray_sads_kept", mode_sads, saved_sads);
    set_rand();
    run_mb(1'b1, 1'b0, 3, 2, 0);

    // Reset after 7 responses on V, then a clean V + DC run.
    set_rand();
    run_mb(1'b1, 1'b0, 2, 0, 7);
    set_rand();
    run_mb(1'b1, 1'b0, 2, 0, 0);

    // Saturation on the narrow-accumulator instance.
    avail_top = 1'b1; avail_left = 1'b1; start_s = 1'b1;
    step();
    start_s = 1'b0;
    prev_s = 1'b0; nreq_s = 0; seen_s = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_s) begin seen_s = 1'b1; break; end
      dp_s.req_ready = 1'b1;
      dp_s.rsp_valid = prev_s;
      dp_s.rsp_sad   = 12'hFFF;
      prev_s = dp_s.req_valid;
      if (dp_s.req_valid) nreq_s++;
      step();
    end
    dp_s.req_ready = 1'b0;
    dp_s.rsp_valid = 1'b0;
    chk("sat_done_seen", seen_s, 1);
    chk("sat_req_count", nreq_s, 64);
    chk("sat_mode_sads", mode_sads_s, {4{12'hFFF}});
    chk("sat_best_sad", best_sad_s, 12'hFFF);
    chk("sat_best_mode", best_mode_s, 0);
    chk("sat_mode_tested", mode_tested_s, 4'b1111);
    chk("sat_err", err_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/intra16_mode_sched.md
Name: intra16_mode_sched

Overview:
- Sequences the shared luma 16x16 residual/SAD datapath across the candidate intra16x16 prediction modes of one macroblock: V=0, H=1, DC=2, Plane=3.
- Issues per-row requests (mode, row) to the datapath and accumulates the returned per-row SADs into per-mode totals.
- Selects the minimum-SAD mode and reports it to the mode-decision stage.
- Sits between the macroblock control FSM and the residual/SAD datapath.

Parameters:
- ROWS, 16, rows per mode evaluation; the row counter is clog2(ROWS) bits.
- ROW_SAD_W, 12, width of a per-row SAD (16*255 = 4080 fits in 12 bits).
- ACC_W, 16, width of a per-mode SAD accumulator (16*4080 = 65280 fits in 16 bits).
- MAX_OUT, 4, maximum number of requests outstanding (issued but not yet answered); valid range 1..ROWS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins evaluation of a macroblock.
- avail_top  in  1  top neighbour available; sampled at an accepted start.
- avail_left  in  1  left neighbour available; sampled at an accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- req_valid  out  1  a row request is presented.
- req_ready  in  1  the datapath accepts the request.
- req_mode  out  2  mode of the current request.
- req_row  out  4  row index of the current request, 0..ROWS-1.
- rsp_valid  in  1  a row-SAD response is presented; responses return in request order and are always accepted.
- rsp_sad  in  ROW_SAD_W  row SAD magnitude.
- done  out  1  one-cycle pulse when a result is ready.
- best_mode  out  2  winning mode; held until the next done.
- best_sad  out  ACC_W  winning SAD; held until the next done.
- mode_sads  out  4*ACC_W  per-mode totals; mode m occupies bits [m*ACC_W +: ACC_W].
- mode_tested  out  4  bit m is set when mode m was evaluated in the last run.
- err  out  1  sticky; set when rsp_valid arrives with no request outstanding; cleared only by reset.

Behaviour:
- Reset (asynchronous assert on reset low): state=IDLE; busy, req_valid, done, err = 0; best_mode = 2 (DC); best_sad, mode_sads, mode_tested, all counters = 0.
- Candidate set, latched at start:
  - V is a candidate iff avail_top.
  - H is a candidate iff avail_left.
  - DC is always a candidate.
  - Plane is a candidate iff avail_top & avail_left.
- Modes are evaluated in ascending index order. Non-candidates are skipped with zero idle cycles.
- IDLE:
  - start -> LOAD: latch the candidate set, clear mode_sads and mode_tested.
  - start while not in IDLE is ignored.
- LOAD (1 cycle): select the lowest candidate mode, clear its accumulator, set issue_cnt = rsp_cnt = 0 -> RUN.
- RUN:
  - req_valid = (issue_cnt < ROWS) & (issue_cnt - rsp_cnt < MAX_OUT), with req_row = issue_cnt.
  - A request is accepted on req_valid & req_ready; issue_cnt then increments.
  - On rsp_valid with a request outstanding: accumulator += rsp_sad, zero-extended, saturating at 2^ACC_W-1; rsp_cnt increments.
  - An accept and a response in the same cycle are both applied.
  - When rsp_cnt reaches ROWS, write the accumulator into mode_sads[mode] and set mode_tested[mode].
    - If a higher candidate exists -> LOAD-equivalent for that mode, without an extra cycle (the first request for the next mode may be valid on the following cycle).
    - Otherwise -> DECIDE.
  - req_valid never asserts for the next mode while responses for the current mode are outstanding.
- DECIDE (1 cycle): best_mode = the tested mode with the minimum total; ties go to the lowest index. best_sad = that total -> DONE.
- DONE (1 cycle): done = 1 and busy = 1 -> IDLE. A start in this cycle is ignored.
- Throughput: with req_ready=1 and a fixed response latency L, each mode takes ROWS + L cycles when L < MAX_OUT.
- Stray rsp_valid (no request outstanding, or in IDLE/LOAD/DECIDE/DONE): ignored for accumulation; err is set.
- reset low mid-run: immediate return to the reset state. Responses still in flight after reset rises count as stray and set err.
- req_mode and req_row are held stable while req_valid=1 and req_ready=0.

Test Plan:
- Only DC available: avail_top=0, avail_left=0, every rsp_sad=10, req_ready=1, latency 2 -> exactly 16 requests, all req_mode=2; done with best_mode=2, best_sad=160, mode_tested=4'b0100.
- All modes available: per-row SADs V=20, H=5, DC=5, Plane=30 -> totals 320/80/80/480; best_mode=1 (tie with DC goes to the lower index), best_sad=80, mode_tested=4'b1111, 64 requests in order V, H, DC, Plane.
- Backpressure: req_ready toggling 1,0,0,1 and response latency 6 with MAX_OUT=4 -> never more than 4 outstanding; fields stable while stalled; totals still correct.
- Saturation: all rows 4095 with ACC_W narrowed to 12 via parameter -> every total 4095; no wrap.
- Stray response and err: rsp_valid in IDLE -> err=1 and mode_sads unchanged; a following normal run still completes with correct totals and err stays 1.
- Reset mid-run: reset low after 7 responses on mode V -> outputs at reset values; a new start with avail_top=1 and avail_left=0 evaluates V then DC from row 0.
